// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared CPU fetch definitions (FSM encoding, reset PC, NOP)
package if_prefetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} pf_state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with async active-low reset and sync clear
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & ((count != (AW+1)'(DEPTH)) | do_pop);
  assign dout    = mem[rptr];
  always_ff @(posedge clk)
    if (do_push & ~clr) mem[wptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch unit with credit-limited fetching and redirect flush
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_npc
);
  localparam int CW = $clog2(DEPTH) + 1;
  pf_state_t state;
  logic [31:0] fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count, out_next;
  logic accept, resp_ok, push, pop, empty;
  logic [63:0] head;
  // outstanding requests reserve FIFO space so every response always has a slot
  assign imem_req  = state == RUN && !redirect_valid &&
                     ({1'b0, fifo_count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_ready;
  assign resp_ok   = imem_rvalid & (outstanding != '0);
  assign out_next  = outstanding + CW'(accept) - CW'(resp_ok);
  assign push      = resp_ok & (state != FLUSH) & ~redirect_valid;
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign out_valid = ~empty;
  assign out_ir    = empty ? NOP : head[63:32];
  assign out_npc   = empty ? 32'h0 : head[31:0];
  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (push),
    .din   ({imem_rdata, resp_pc + 32'd4}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (fifo_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= out_next;
        state    <= out_next != '0 ? FLUSH : RUN;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (state == BOOT) state <= RUN;
        if (state == FLUSH && resp_ok) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= RUN;
        end
      end
    end
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, is the prefetch FIFO entry count and SHALL be a power of two no smaller than 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address, word aligned.
REQ-007 imem_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  response valid, one pulse per accepted request, returned in order.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address, word aligned.
REQ-012 out_valid  output  1  instruction available to the IF/ID register.
REQ-013 out_ready  input  1  IF/ID register accepts (deasserted on stall).
REQ-014 out_ir  output  32  instruction word.
REQ-015 out_npc  output  32  fetch address of out_ir plus 4.

Function
REQ-016 FSM states: BOOT, RUN, FLUSH.
- BOOT: entered from reset, lasts one cycle, no request, then goes to RUN.
- RUN: normal fetching.
- FLUSH: stale responses still in flight.
REQ-017 In RUN, imem_req SHALL be 1 only when fifo_count + outstanding < DEPTH; imem_addr = fetch_pc.
REQ-018 On a request handshake (imem_req & imem_ready): fetch_pc += 4 (mod 2^32) and outstanding += 1.
REQ-019 The response handshake rules are:
- imem_rvalid decrements outstanding.
- Outside FLUSH, each response SHALL push {imem_rdata, resp_pc+4} into the FIFO; resp_pc then advances by 4.
- An accepted request and a response in the same cycle leave outstanding unchanged.
REQ-020 Response-to-out_valid latency SHALL be 1 cycle minimum; there is no combinational bypass from imem_rdata to out_ir.
REQ-021 out_valid = FIFO non-empty; out_ir/out_npc = head entry; pop on out_valid & out_ready.
- Push and pop in the same cycle on a full FIFO SHALL be legal and leave the count unchanged.
REQ-022 Head entry and out_valid SHALL hold stable while out_ready = 0.
REQ-023 On redirect_valid, regardless of state, the next edge SHALL:
- clear the FIFO (out_valid=0);
- load fetch_pc and resp_pc with redirect_pc;
- discard any same-cycle push and pop;
- set drop_cnt = outstanding after same-cycle accounting;
- go to FLUSH if drop_cnt ≠ 0, else RUN.
REQ-024 imem_req SHALL be 0 during a redirect cycle and in BOOT/FLUSH.
REQ-025 In FLUSH, each imem_rvalid decrements drop_cnt and is discarded.
- Reaching 0 SHALL return to RUN with the first request on the following cycle.
REQ-026 A redirect while in FLUSH SHALL restart the flush with the updated outstanding count.
REQ-027 Counter widths SHALL be clog2(DEPTH)+1 bits; FIFO pointers clog2(DEPTH) bits and wrap naturally.
REQ-028 Responses with outstanding = 0 are a protocol violation, SHALL be ignored, and SHALL not underflow.

Reset
REQ-029 Reset value of every output SHALL be:
- imem_req=0;
- imem_addr=RESET_PC;
- out_valid=0, out_ir=0, out_npc=0.
REQ-030 Reset value of every internal register SHALL be:
- fetch_pc=resp_pc=RESET_PC;
- outstanding=drop_cnt=fifo_count=0;
- state=BOOT.
REQ-031 Reset asserted mid-operation SHALL abandon in-flight requests; the memory is reset by the same rst.

Structure
REQ-032 The shared CPU package SHALL hold the FSM state encoding, RESET_PC default and the NOP encoding (32'h0).
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised WIDTH=64, DEPTH), with a synchronous clear input.
- This top level holds the FSM, PC, outstanding and drop counters.

Verification
REQ-034 Reset release with a zero-wait memory and out_ready=1 -> first out: imem_addr 0x0 issued on cycle 2; out_valid on cycle 4 with out_npc=0x4; then one instruction per cycle (npc 0x8, 0xC, ...).
REQ-035 out_ready=0 for 10 cycles -> exactly 4 entries buffered, imem_req=0, head stable; release -> 4 pops on consecutive cycles with no gap or duplicate.
REQ-036 Redirect to 0x40 with 2 requests outstanding (memory latency 3) -> out_valid=0 next cycle; the 2 responses are dropped; the first output has out_npc=0x44.
REQ-037 Redirect coinciding with an accepted request, a response and a pop -> no entry from old PC appears; outstanding is consistent (drop_cnt=prior+1-1).
REQ-038 Back-to-back redirects (0x40 then 0x80) during FLUSH -> only 0x80-stream instructions emerge; no deadlock.
REQ-039 Random imem_ready/out_ready/latency for 10k cycles against a reference PC model -> output stream matches program order; fifo_count ≤ 4 and outstanding ≤ 4 always.
